multiplicador_goldschmidt: RTL



---
 rtl/multiplicador_goldschmidt.sv | 91 +++++++++
 1 files changed

// File: rtl/multiplicador_goldschmidt.sv
// Radix-2 shift-add unsigned fixed-point multiplier (Q(WIDTH-FRAC).FRAC), one
// multiplier bit per clock, fixed WIDTH-cycle latency, start/busy/done handshake.
module multiplicador_goldschmidt #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 30
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] multiplicando,
  input  logic [WIDTH-1:0] multiplicador,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] produto,
  output logic             overflow,
  output logic             state_dbg_o
);

  // Handshake: start is taken only on an edge where the unit is idle (busy=0,
  // which includes the done cycle); a start seen while busy is dropped, never
  // queued. done is a one-cycle pulse; produto/overflow hold until the next done.

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int AW = 2 * WIDTH;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [AW-1:0]    acc_q;
  logic [AW-1:0]    acc_d;
  logic [CW-1:0]    cnt_q;
  logic             last_bit;

  // Partial product for the bit under the counter, aligned by its weight.
  always_comb begin
    acc_d = acc_q;
    if (b_q[cnt_q]) begin
      acc_d = acc_q + ({{WIDTH{1'b0}}, a_q} << cnt_q);
    end
  end

  assign last_bit    = (cnt_q == CW'(WIDTH - 1));
  assign state_dbg_o = state_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      produto  <= '0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= multiplicando;
            b_q     <= multiplicador;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy    <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 1'b1;
          if (last_bit) begin
            // Keep FRAC fraction bits (floor); integer bits above the format flag overflow.
            produto  <= acc_d[WIDTH+FRAC-1:FRAC];
            overflow <= |acc_d[AW-1:WIDTH+FRAC];
            done     <= 1'b1;
            busy     <= 1'b0;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
